// File: rtl/xoodoo_perm_ctrl.sv
// Iterative 12-round Xoodoo permutation: a 384-bit state register stepped through
// ROUNDS_PER_CYCLE combinational rounds per clock, with valid/ready in and out.

// Round-constant generator. The 6-bit state is {p[2:0], s[2:0]} and the constant is
// the odd value (2*p+1) placed at bit offset s. 6'b101011 yields 32'h58, the first constant.
module xoodoo_rc (
  input  logic [5:0]  rc_state,
  output logic [31:0] rc,
  output logic [5:0]  rc_state_next
);

  logic [2:0] p;
  logic [2:0] s;

  assign p  = rc_state[5:3];
  assign s  = rc_state[2:0];
  assign rc = {28'd0, p, 1'b1} << s;

  // Twelve-step cycle; any state outside it falls back to the first constant.
  always_comb begin
    rc_state_next = 6'b101011;
    case (rc_state)
      6'b101011: rc_state_next = 6'b011011; // 058 -> 038
      6'b011011: rc_state_next = 6'b111110; // 038 -> 3C0
      6'b111110: rc_state_next = 6'b110100; // 3C0 -> 0D0
      6'b110100: rc_state_next = 6'b100101; // 0D0 -> 120
      6'b100101: rc_state_next = 6'b010010; // 120 -> 014
      6'b010010: rc_state_next = 6'b001101; // 014 -> 060
      6'b001101: rc_state_next = 6'b101010; // 060 -> 02C
      6'b101010: rc_state_next = 6'b011111; // 02C -> 380
      6'b011111: rc_state_next = 6'b111100; // 380 -> 0F0
      6'b111100: rc_state_next = 6'b110101; // 0F0 -> 1A0
      6'b110101: rc_state_next = 6'b100001; // 1A0 -> 012
      6'b100001: rc_state_next = 6'b101011; // 012 -> 058
      default:   rc_state_next = 6'b101011;
    endcase
  end

endmodule

// One Xoodoo round. Lane (plane y, column x) lives at bits [32*(4*y+x) +: 32].
module xoodoo_round (
  input  logic [383:0] state_in,
  input  logic [31:0]  rc,
  output logic [383:0] state_out
);

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  logic [31:0] a [3][4];
  logic [31:0] w [3][4];
  logic [31:0] c [3][4];
  logic [31:0] p [4];
  logic [31:0] e [4];

  always_comb begin
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) begin
        a[y][x] = state_in[32*(4*y+x) +: 32];
      end
    end
    // theta: column parity folded back from the neighbouring column
    for (int x = 0; x < 4; x++) begin
      p[x] = a[0][x] ^ a[1][x] ^ a[2][x];
    end
    for (int x = 0; x < 4; x++) begin
      e[x] = rotl(p[(x+3)%4], 5) ^ rotl(p[(x+3)%4], 14);
    end
    // rho-west merged with theta; plane 1 moves one column, plane 2 rotates by 11
    for (int x = 0; x < 4; x++) begin
      w[0][x] = a[0][x] ^ e[x];
      w[1][x] = a[1][(x+3)%4] ^ e[(x+3)%4];
      w[2][x] = rotl(a[2][x] ^ e[x], 11);
    end
    w[0][0] = w[0][0] ^ rc;
    for (int y = 0; y < 3; y++) begin
      for (int x = 0; x < 4; x++) begin
        c[y][x] = w[y][x] ^ (~w[(y+1)%3][x] & w[(y+2)%3][x]);
      end
    end
    // rho-east
    state_out = '0;
    for (int x = 0; x < 4; x++) begin
      state_out[32*x     +: 32] = c[0][x];
      state_out[32*(4+x) +: 32] = rotl(c[1][x], 1);
      state_out[32*(8+x) +: 32] = rotl(c[2][(x+2)%4], 8);
    end
  end

endmodule

// ROUNDS chained rounds, each pulling its constant from the running rc state.
module xoodoo_n_rounds #(
  parameter int ROUNDS = 2
) (
  input  logic [383:0] state_in,
  input  logic [5:0]   rc_state_in,
  output logic [383:0] state_out,
  output logic [5:0]   rc_state_out
);

  logic [383:0] st  [ROUNDS+1];
  logic [5:0]   rs  [ROUNDS+1];
  logic [31:0]  rcv [ROUNDS];

  assign st[0] = state_in;
  assign rs[0] = rc_state_in;

  for (genvar i = 0; i < ROUNDS; i++) begin : g_round
    xoodoo_rc u_rc (
      .rc_state      (rs[i]),
      .rc            (rcv[i]),
      .rc_state_next (rs[i+1])
    );
    xoodoo_round u_round (
      .state_in  (st[i]),
      .rc        (rcv[i]),
      .state_out (st[i+1])
    );
  end

  assign state_out    = st[ROUNDS];
  assign rc_state_out = rs[ROUNDS];

endmodule

module xoodoo_perm_ctrl #(
  parameter int         ROUNDS_PER_CYCLE = 2,
  parameter int         NUM_ROUNDS       = 12,
  parameter logic [5:0] RC_INIT          = 6'b101011
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [383:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  output logic [383:0] dout,
  output logic         dout_valid,
  input  logic         dout_ready,
  output logic         busy,
  output logic [3:0]   round_idx
);

  localparam int         ITER     = NUM_ROUNDS / ROUNDS_PER_CYCLE;
  localparam logic [3:0] CNT_LAST = 4'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } fsm_t;

  fsm_t         fsm;
  fsm_t         fsm_next;
  logic [383:0] state_reg;
  logic [5:0]   rc_reg;
  logic [3:0]   cnt;
  logic         load;
  logic [383:0] nr_state;
  logic [5:0]   nr_rc;

  xoodoo_n_rounds #(
    .ROUNDS (ROUNDS_PER_CYCLE)
  ) u_n_rounds (
    .state_in     (state_reg),
    .rc_state_in  (rc_reg),
    .state_out    (nr_state),
    .rc_state_out (nr_rc)
  );

  // Handshakes: a word moves on any rising edge where valid and ready are both 1.
  // din_ready never depends on din_valid; dout/dout_valid hold until dout_ready.
  // In DONE, popping the result frees the register, so a new din loads on the same edge.
  always_comb begin
    fsm_next  = fsm;
    din_ready = 1'b0;
    load      = 1'b0;
    case (fsm)
      S_IDLE: begin
        din_ready = ~rst;
        if (din_valid && !rst) begin
          load     = 1'b1;
          fsm_next = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt == CNT_LAST) fsm_next = S_DONE;
      end
      S_DONE: begin
        din_ready = dout_ready;
        if (dout_ready) begin
          if (din_valid) begin
            load     = 1'b1;
            fsm_next = S_RUN;
          end else begin
            fsm_next = S_IDLE;
          end
        end
      end
      default: fsm_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fsm <= S_IDLE;
    else     fsm <= fsm_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= '0;
      rc_reg    <= RC_INIT;
      cnt       <= '0;
    end else if (load) begin
      state_reg <= din;
      rc_reg    <= RC_INIT;
      cnt       <= '0;
    end else if (fsm == S_RUN) begin
      state_reg <= nr_state;
      rc_reg    <= nr_rc;
      if (cnt != CNT_LAST) cnt <= cnt + 4'd1;
    end
  end

  assign dout       = state_reg;
  assign dout_valid = (fsm == S_DONE);
  assign busy       = (fsm == S_RUN);
  assign round_idx  = busy ? cnt : 4'd0;

endmodule

// File: tb/tb_xoodoo_perm_ctrl.sv
// Bench for xoodoo_perm_ctrl: vector table, multi-cycle handshake sequences and a
// lane-array Xoodoo[12] reference model.
module tb_xoodoo_perm_ctrl;

  localparam int ITER = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [383:0] din, dout, p1_dout, p12_dout;
  logic         din_valid, din_ready, dout_valid, dout_ready, busy;
  logic [3:0]   round_idx, p1_round_idx, p12_round_idx;
  logic         p1_din_valid, p1_din_ready, p1_dout_valid, p1_dout_ready, p1_busy;
  logic         p12_din_valid, p12_din_ready, p12_dout_valid, p12_dout_ready, p12_busy;

  xoodoo_perm_ctrl dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .busy(busy),
    .round_idx(round_idx)
  );

  xoodoo_perm_ctrl #(.ROUNDS_PER_CYCLE(1)) dut_r1 (
    .clk(clk), .rst(rst), .din(din), .din_valid(p1_din_valid), .din_ready(p1_din_ready),
    .dout(p1_dout), .dout_valid(p1_dout_valid), .dout_ready(p1_dout_ready), .busy(p1_busy),
    .round_idx(p1_round_idx)
  );

  xoodoo_perm_ctrl #(.ROUNDS_PER_CYCLE(12)) dut_r12 (
    .clk(clk), .rst(rst), .din(din), .din_valid(p12_din_valid), .din_ready(p12_din_ready),
    .dout(p12_dout), .dout_valid(p12_dout_valid), .dout_ready(p12_dout_ready), .busy(p12_busy),
    .round_idx(p12_round_idx)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [383:0] exp_q[$];

  logic [31:0] rc_tab [12] = '{32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
                               32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012};

  typedef struct {
    logic [383:0] din;
    logic [383:0] exp_dout;
    int           exp_lat;
  } vec_t;
  vec_t tab [6];

  function automatic logic [31:0] rol(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Xoodoo[12] on a 3x4 lane array, straight from the round definition.
  function automatic logic [383:0] xoodoo_ref(input logic [383:0] s);
    logic [31:0] a [3][4];
    logic [31:0] b [3][4];
    logic [31:0] pc [4];
    logic [383:0] r;
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) a[y][x] = s[32*(4*y+x) +: 32];
    for (int rnd = 0; rnd < 12; rnd++) begin
      for (int x = 0; x < 4; x++) pc[x] = a[0][x] ^ a[1][x] ^ a[2][x];
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++)
          a[y][x] = a[y][x] ^ rol(pc[(x+3)%4], 5) ^ rol(pc[(x+3)%4], 14);
      for (int x = 0; x < 4; x++) begin
        b[0][x] = a[0][x];
        b[1][x] = a[1][(x+3)%4];
        b[2][x] = rol(a[2][x], 11);
      end
      b[0][0] = b[0][0] ^ rc_tab[rnd];
      for (int y = 0; y < 3; y++)
        for (int x = 0; x < 4; x++)
          a[y][x] = b[y][x] ^ (~b[(y+1)%3][x] & b[(y+2)%3][x]);
      for (int x = 0; x < 4; x++) begin
        b[0][x] = a[0][x];
        b[1][x] = rol(a[1][x], 1);
        b[2][x] = rol(a[2][(x+2)%4], 8);
      end
      a = b;
    end
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 4; x++) r[32*(4*y+x) +: 32] = a[y][x];
    return r;
  endfunction

  function automatic logic [383:0] rand384();
    logic [383:0] r;
    for (int i = 0; i < 12; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string name, input logic [383:0] act, input logic [383:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Leaves the bench at the first negedge after the accepting edge.
  task automatic start_perm(input logic [383:0] d);
    int k;
    @(negedge clk);
    din = d;
    din_valid = 1'b1;
    k = 0;
    while (!din_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("din_ready_wait", 384'(din_ready), 384'(1));
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  // lat counts rising edges since acceptance until dout_valid is seen.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!dout_valid && lat < 40) begin
      check("round_idx", 384'(round_idx), 384'(lat));
      check("busy_excl", 384'({busy & dout_valid, busy & din_ready}), 384'(0));
      @(negedge clk);
      lat++;
    end
    check("busy_excl_done", 384'({busy & dout_valid, busy & din_ready}), 384'(0));
  endtask

  task automatic pop();
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
  endtask

  initial begin
    int lat, l1, l12, sent, got, last;
    logic pending;
    logic [383:0] ra, rb, held;

    rst = 1'b1;
    din = '0;
    din_valid = 1'b0;
    dout_ready = 1'b0;
    p1_din_valid = 1'b0;  p1_dout_ready = 1'b0;
    p12_din_valid = 1'b0; p12_dout_ready = 1'b0;

    tab[0].din = '0;
    tab[1].din = '1;
    tab[2].din = {12{32'h01234567}};
    tab[3].din = 384'd1;
    tab[4].din = rand384();
    tab[5].din = rand384();
    for (int i = 0; i < 6; i++) begin
      tab[i].exp_dout = xoodoo_ref(tab[i].din);
      tab[i].exp_lat  = ITER;
    end

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_dout_valid", 384'(dout_valid), 384'(0));
    check("rst_busy", 384'(busy), 384'(0));
    check("rst_din_ready", 384'(din_ready), 384'(0));
    check("rst_round_idx", 384'(round_idx), 384'(0));
    check("rst_dout", dout, '0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_din_ready", 384'(din_ready), 384'(1));

    // Vector table: latency and result
    for (int i = 0; i < 6; i++) begin
      start_perm(tab[i].din);
      wait_done(lat);
      check($sformatf("vec%0d_latency", i), 384'(lat), 384'(tab[i].exp_lat));
      check($sformatf("vec%0d_dout", i), dout, tab[i].exp_dout);
      pop();
      check($sformatf("vec%0d_idle", i), 384'({dout_valid, busy, din_ready}), 384'(3'b001));
    end

    // Reset in the middle of a run at cnt=3
    start_perm(rand384());
    repeat (3) @(negedge clk);
    check("t1_cnt3", 384'(round_idx), 384'(3));
    rst = 1'b1;
    #1;
    check("t1_dout_valid", 384'(dout_valid), 384'(0));
    check("t1_busy", 384'(busy), 384'(0));
    check("t1_round_idx", 384'(round_idx), 384'(0));
    check("t1_din_ready", 384'(din_ready), 384'(0));
    check("t1_dout", dout, '0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t1_release_ready", 384'(din_ready), 384'(1));

    // Backpressure: result held, din ignored
    ra = rand384();
    held = xoodoo_ref(ra);
    start_perm(ra);
    wait_done(lat);
    for (int i = 0; i < 10; i++) begin
      check("t3_dout_hold", dout, held);
      check("t3_flags", 384'({dout_valid, din_ready, busy}), 384'(3'b100));
      din = rand384();
      din_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    din_valid = 1'b0;
    check("t3_dout_final", dout, held);
    pop();
    check("t3_idle", 384'(dout_valid), 384'(0));

    // Back-to-back with simultaneous pop and push
    @(negedge clk);
    din = rand384();
    din_valid = 1'b1;
    dout_ready = 1'b1;
    pending = 1'b0;
    sent = 0; got = 0; last = -1;
    for (int cyc = 0; cyc < 300 && got < 4; cyc++) begin
      if (pending) begin
        pending = 1'b0;
        if (sent < 4) din = rand384();
        else din_valid = 1'b0;
      end
      if (dout_valid) begin
        if (exp_q.size() == 0) check("t4_unexpected_out", 384'(1), 384'(0));
        else check("t4_dout", dout, exp_q.pop_front());
        if (last >= 0) check("t4_interval", 384'(cyc - last), 384'(ITER + 1));
        last = cyc;
        got++;
      end
      if (din_valid && din_ready) begin
        exp_q.push_back(xoodoo_ref(din));
        sent++;
        pending = 1'b1;
      end
      @(negedge clk);
    end
    dout_ready = 1'b0;
    din_valid = 1'b0;
    check("t4_count", 384'(got), 384'(4));
    check("t4_queue_empty", 384'(exp_q.size()), 384'(0));
    check("t4_idle", 384'(dout_valid), 384'(0));

    // din during RUN is ignored; taken in DONE with no bubble
    ra = rand384();
    rb = rand384();
    start_perm(ra);
    din = rb;
    din_valid = 1'b1;
    wait_done(lat);
    check("t6_latency_a", 384'(lat), 384'(ITER));
    check("t6_dout_a", dout, xoodoo_ref(ra));
    dout_ready = 1'b1;
    @(negedge clk);
    dout_ready = 1'b0;
    din_valid = 1'b0;
    check("t6_accept_in_done", 384'({busy, dout_valid}), 384'(2'b10));
    wait_done(lat);
    check("t6_latency_b", 384'(lat), 384'(ITER));
    check("t6_dout_b", dout, xoodoo_ref(rb));
    pop();

    // Other rounds-per-cycle settings on the all-zero state
    @(negedge clk);
    din = '0;
    p1_din_valid = 1'b1;
    p12_din_valid = 1'b1;
    check("t5_ready", 384'({p1_din_ready, p12_din_ready}), 384'(2'b11));
    @(negedge clk);
    p1_din_valid = 1'b0;
    p12_din_valid = 1'b0;
    l1 = -1;
    l12 = -1;
    for (int c = 0; c < 40; c++) begin
      if (p1_dout_valid && l1 < 0) l1 = c;
      if (p12_dout_valid && l12 < 0) l12 = c;
      if (l1 >= 0 && l12 >= 0) break;
      @(negedge clk);
    end
    check("t5_latency_r1", 384'(l1), 384'(12));
    check("t5_latency_r12", 384'(l12), 384'(1));
    check("t5_dout_r1", p1_dout, tab[0].exp_dout);
    check("t5_dout_r12", p12_dout, tab[0].exp_dout);
    p1_dout_ready = 1'b1;
    p12_dout_ready = 1'b1;
    @(negedge clk);
    p1_dout_ready = 1'b0;
    p12_dout_ready = 1'b0;
    check("t5_idle", 384'({p1_dout_valid, p12_dout_valid}), 384'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
